// File: rtl/ltc2308_reader.sv
// ==========================================================================
// Module   : ltc2308_reader
// Function : LTC2308 SPI reader with box-car averaging of 2^AVG_LOG2 samples
// Revision : 1.0
// ==========================================================================
`default_nettype none

module ltc2308_reader #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int CHANNEL     = 0,
    parameter int AVG_LOG2    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic [11:0] value,
    output logic        value_valid
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMR_W = $clog2(CONV_CYCLES + 2);
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W = 12 + AVG_LOG2;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] CONVST_LAST = TMR_W'(1);
    localparam logic [TMR_W-1:0] CONV_LAST   = TMR_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [4:0]       HALF_LAST   = 5'd23;

    localparam logic [2:0] CH       = CHANNEL[2:0];
    localparam logic [5:0] CFG_WORD = {1'b1, CH[0], CH[2], CH[1], 1'b1, 1'b0};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONVST  = 3'd1;
    localparam logic [2:0] S_CONVERT = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_ACCUM   = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [TMR_W-1:0] r_tmr;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_half;
    logic [5:0]       r_cfg;
    logic [11:0]      r_shift;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_prime;
    logic             r_en_q;

    logic             w_div_last;
    logic [4:0]       w_half_inc;
    logic [ACC_W-1:0] w_sum;
    logic             w_convst_n;
    logic             w_sck_n;
    logic             w_sdi_n;
    logic             w_capture;
    logic [5:0]       w_cfg_n;

    assign w_div_last = (r_div == DIV_LAST);
    assign w_half_inc = r_half + 5'd1;
    assign w_sum      = r_acc + ACC_W'(r_shift);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (enable) w_next = S_CONVST;
            S_CONVST:  if (r_tmr == CONVST_LAST) w_next = S_CONVERT;
            S_CONVERT: if (r_tmr == CONV_LAST) w_next = S_SHIFT;
            S_SHIFT:   if (w_div_last && (r_half == HALF_LAST)) w_next = S_ACCUM;
            S_ACCUM:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Next values for the registered pins: even half-periods are SCK low,
    // odd ones high; config bits advance at each new low phase.
    always_comb begin
        w_convst_n = (w_next == S_CONVST);
        w_sck_n    = 1'b0;
        w_sdi_n    = 1'b0;
        w_capture  = 1'b0;
        w_cfg_n    = r_cfg;
        if ((r_state == S_CONVERT) && (w_next == S_SHIFT)) begin
            w_sdi_n = CFG_WORD[5];
            w_cfg_n = {CFG_WORD[4:0], 1'b0};
        end else if ((r_state == S_SHIFT) && (w_next == S_SHIFT)) begin
            w_sck_n = adc_sck;
            w_sdi_n = adc_sdi;
            if (w_div_last) begin
                w_sck_n = w_half_inc[0];
                if (w_half_inc[0]) begin
                    w_capture = 1'b1;
                end else begin
                    w_sdi_n = r_cfg[5];
                    w_cfg_n = {r_cfg[4:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_convst  <= 1'b0;
            adc_sck     <= 1'b0;
            adc_sdi     <= 1'b0;
            value       <= 12'd0;
            value_valid <= 1'b0;
            r_tmr       <= '0;
            r_div       <= '0;
            r_half      <= 5'd0;
            r_cfg       <= 6'd0;
            r_shift     <= 12'd0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_prime     <= 1'b1;
            r_en_q      <= 1'b0;
        end else begin
            adc_convst  <= w_convst_n;
            adc_sck     <= w_sck_n;
            adc_sdi     <= w_sdi_n;
            r_cfg       <= w_cfg_n;
            r_en_q      <= enable;
            value_valid <= 1'b0;
            r_tmr       <= (w_next != r_state) ? '0 : r_tmr + TMR_W'(1);

            if ((r_state == S_SHIFT) && (w_next == S_SHIFT)) begin
                if (w_div_last) begin
                    r_div  <= '0;
                    r_half <= w_half_inc;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end else begin
                r_div  <= '0;
                r_half <= 5'd0;
            end

            if (w_capture) begin
                r_shift <= {r_shift[10:0], adc_sdo};
            end

            // The ADC applies a config word to the following conversion, so a
            // fresh start must throw away one read.
            if ((r_state == S_IDLE) && enable && !r_en_q) begin
                r_prime <= 1'b1;
            end

            if (r_state == S_ACCUM) begin
                if (r_prime) begin
                    r_prime <= 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    value       <= 12'(w_sum >> AVG_LOG2);
                    value_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ltc2308_reader.sv
// ==========================================================================
// Module   : tb_ltc2308_reader
// Function : Scoreboard bench for ltc2308_reader (AVG_LOG2=2 and 0, CHANNEL=5)
// Revision : 1.0
// ==========================================================================
`default_nettype none

module tb_ltc2308_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        adc_sdo;

    logic        convst_a, sck_a, sdi_a, valid_a;
    logic [11:0] value_a;
    logic        convst_b, sck_b, sdi_b, valid_b;
    logic [11:0] value_b;

    ltc2308_reader #(.CLK_DIV(2), .CONV_CYCLES(80), .CHANNEL(5), .AVG_LOG2(0)) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .adc_convst(convst_a), .adc_sck(sck_a), .adc_sdi(sdi_a), .adc_sdo(adc_sdo),
        .value(value_a), .value_valid(valid_a)
    );

    ltc2308_reader #(.CLK_DIV(2), .CONV_CYCLES(80), .CHANNEL(5), .AVG_LOG2(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .adc_convst(convst_b), .adc_sck(sck_b), .adc_sdi(sdi_b), .adc_sdo(adc_sdo),
        .value(value_b), .value_valid(valid_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    task automatic push_a(input int v, input int c);
        exp_t e;
        e.v = v;
        e.c = c;
        qa.push_back(e);
    endtask

    task automatic push_b(input int v, input int c);
        exp_t e;
        e.v = v;
        e.c = c;
        qb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        for (int i = 0; i < 4000 && cyc != c; i++) @(negedge clk);
        if (cyc != c) check("wait_timeout", cyc, c);
    endtask

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // ADC model: one table entry per CONVST; MSB ready before the first
    // SCK, next bit presented after every SCK fall.
    logic [11:0] samples [0:19];
    logic [11:0] cur_word;
    int          adc_idx = 0;
    int          bit_pos = -1;

    always @(posedge convst_a) begin
        cur_word = (adc_idx < 20) ? samples[adc_idx] : 12'h000;
        adc_idx  = adc_idx + 1;
        adc_sdo  = cur_word[11];
        bit_pos  = 10;
    end

    always @(negedge sck_a) begin
        if (bit_pos >= 0) begin
            adc_sdo = cur_word[bit_pos];
            bit_pos = bit_pos - 1;
        end
    end

    // Monitor: scoreboard pops plus per-conversion SPI protocol checks
    logic        convst_prev = 1'b0;
    logic        sck_prev    = 1'b0;
    logic [11:0] value_a_prev = 12'd0;
    logic [11:0] value_b_prev = 12'd0;
    logic [11:0] sdi_word    = 12'd0;
    int          rise_cnt    = 0;
    int          last_rise   = 0;
    int          hi_cnt      = 0;
    int          last_convst = -1;
    logic        trk_ok      = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            convst_prev  = 1'b0;
            sck_prev     = 1'b0;
            trk_ok       = 1'b0;
            rise_cnt     = 0;
            hi_cnt       = 0;
            value_a_prev = value_a;
            value_b_prev = value_b;
        end else begin
            if (valid_a) begin
                if (qa.size() == 0) check("a_unexpected_valid", 1, 0);
                else begin
                    e = qa.pop_front();
                    check("a_value", int'(value_a), e.v);
                    if (e.c >= 0) check("a_valid_cycle", cyc, e.c);
                end
            end else if (value_a != value_a_prev) check("a_value_stable", int'(value_a), int'(value_a_prev));
            if (valid_b) begin
                if (qb.size() == 0) check("b_unexpected_valid", 1, 0);
                else begin
                    e = qb.pop_front();
                    check("b_value", int'(value_b), e.v);
                    if (e.c >= 0) check("b_valid_cycle", cyc, e.c);
                end
            end else if (value_b != value_b_prev) check("b_value_stable", int'(value_b), int'(value_b_prev));
            value_a_prev = value_a;
            value_b_prev = value_b;

            if (convst_a) begin
                hi_cnt++;
                check("sck_low_in_convst", int'(sck_a), 0);
            end
            if (convst_a && !convst_prev) begin
                if (trk_ok) begin
                    check("sck_rises", rise_cnt, 12);
                    check("sdi_word", int'(sdi_word), 'hE80);
                end
                trk_ok      = 1'b1;
                rise_cnt    = 0;
                sdi_word    = 12'd0;
                last_convst = cyc;
            end
            if (!convst_a && convst_prev) begin
                check("convst_width", hi_cnt, 2);
                hi_cnt = 0;
            end
            if (sck_a && !sck_prev) begin
                rise_cnt++;
                sdi_word = {sdi_word[10:0], sdi_a};
                if (rise_cnt > 1) check("sck_period", cyc - last_rise, 4);
                last_rise = cyc;
            end
            convst_prev = convst_a;
            sck_prev    = sck_a;
        end
    end

    initial begin
        for (int i = 0; i < 20; i++) samples[i] = 12'h000;
        samples[0]  = 12'h123;
        samples[1]  = 12'd100;
        samples[2]  = 12'd101;
        samples[3]  = 12'd102;
        samples[4]  = 12'd103;
        samples[5]  = 12'hFFF;
        samples[6]  = 12'hFFF;
        samples[7]  = 12'hFFF;
        samples[8]  = 12'hFFF;
        samples[9]  = 12'hABC;
        samples[10] = 12'hABC;
        samples[11] = 12'h555;
        samples[12] = 12'h777;
        samples[13] = 12'hABC;
        samples[14] = 12'h3C3;
        samples[15] = 12'h777;
        samples[16] = 12'd200;

        // Conversion k occupies cycles 132k..132k+131; strobe at 132(k+1)
        push_a(100, 264);    push_a(101, 396);    push_a(102, 528);    push_a(103, 660);
        push_a('hFFF, 792);  push_a('hFFF, 924);  push_a('hFFF, 1056); push_a('hFFF, 1188);
        push_a('hABC, 1320); push_a('hABC, 1452); push_a('h555, 1584);
        push_b(101, 660);    push_b('hFFF, 1188);

        reset   = 1'b1;
        enable  = 1'b1;
        adc_sdo = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("reset_outputs",
                  int'({convst_a, sck_a, sdi_a, valid_a, value_a, convst_b, sck_b, sdi_b, valid_b, value_b}), 0);
        end
        reset = 1'b0;
        @(negedge clk); check("convst_cycle1", int'(convst_a), 1);
        @(negedge clk); check("convst_cycle2", int'(convst_a), 1);
        @(negedge clk); check("convst_cycle3", int'(convst_a), 0);

        wait_until(1540);
        enable = 1'b0;
        wait_until(1900);
        check("idle_no_new_convst", last_convst, 1453);
        check("idle_sck_low", int'(sck_a), 0);

        // Retained acc: ABC+ABC+555+ABC = 9609 -> 2402
        push_a('hABC, 2164);
        push_b('h962, 2164);
        enable = 1'b1;

        wait_until(2262);
        check("sck_before_abort", int'(sck_a), 1);
        reset = 1'b1;
        @(negedge clk);
        check("sck_abort", int'(sck_a), 0);
        repeat (2) @(negedge clk);
        push_a(200, 264);
        reset = 1'b0;

        wait_until(300);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
